// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic pipeline stage register with a valid/ready handshake.
// Replaces the fixed per-stage latch pairs (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries a payload and a control bundle. Empty slots present all-zero control,
// so downstream logic sees a NOP bubble.
//
// Parameters:
//   DATA_W  payload width
//   CTRL_W  control bundle width (all-zero means NOP)
//   SKID    1: two-entry skid buffer with registered in_ready
//           0: single entry with combinational in_ready
//   CNT_W   width of the saturating stall-cycle counter
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous kill of every held entry
//   in_valid/in_ready     upstream handshake, with in_data/in_ctrl
//   out_valid/out_ready   downstream handshake, with out_data/out_ctrl
//   occ                   entries currently held (0..2)
//   stall_cnt             cycles with out_valid & !out_ready, saturating
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 20,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  logic              w_in_fire;
  logic              w_out_fire;
  logic [DATA_W-1:0] r_head_data;
  logic [CTRL_W-1:0] r_head_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  assign out_data  = r_head_data;
  assign out_ctrl  = out_valid ? r_head_ctrl : '0;
  assign stall_cnt = r_stall_cnt;

  if (SKID != 0) begin : g_skid
    state_e            r_state;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    // in_ready comes straight from a flop so the upstream ready path is cut.
    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != StEmpty);
    assign occ       = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state     <= StEmpty;
        r_in_ready  <= 1'b1;
        r_head_data <= '0;
        r_head_ctrl <= '0;
        r_skid_data <= '0;
        r_skid_ctrl <= '0;
      end else if (flush) begin
        // Flush wins over any same-cycle accept; the incoming beat is dropped.
        r_state     <= StEmpty;
        r_in_ready  <= 1'b1;
        r_head_data <= '0;
        r_head_ctrl <= '0;
        r_skid_data <= '0;
        r_skid_ctrl <= '0;
      end else begin
        unique case (r_state)
          StEmpty: begin
            if (w_in_fire) begin
              r_state     <= StOne;
              r_head_data <= in_data;
              r_head_ctrl <= in_ctrl;
            end
          end
          StOne: begin
            if (w_in_fire && w_out_fire) begin
              r_head_data <= in_data;
              r_head_ctrl <= in_ctrl;
            end else if (w_in_fire) begin
              // Downstream stalled: park the new beat behind the head.
              r_state     <= StFull;
              r_in_ready  <= 1'b0;
              r_skid_data <= in_data;
              r_skid_ctrl <= in_ctrl;
            end else if (w_out_fire) begin
              r_state <= StEmpty;
            end
          end
          StFull: begin
            if (w_out_fire) begin
              r_state     <= StOne;
              r_in_ready  <= 1'b1;
              r_head_data <= r_skid_data;
              r_head_ctrl <= r_skid_ctrl;
            end
          end
          default: begin
            r_state    <= StEmpty;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end
  end else begin : g_single
    logic r_valid;

    assign in_ready  = !r_valid | out_ready;
    assign out_valid = r_valid;
    assign occ       = {1'b0, r_valid};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid     <= 1'b0;
        r_head_data <= '0;
        r_head_ctrl <= '0;
      end else if (flush) begin
        r_valid     <= 1'b0;
        r_head_data <= '0;
        r_head_ctrl <= '0;
      end else if (w_in_fire) begin
        r_valid     <= 1'b1;
        r_head_data <= in_data;
        r_head_ctrl <= in_ctrl;
      end else if (w_out_fire) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Stall counter ignores flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and random checks of pipe_stage_buf. Three instances share one
// stimulus stream: 0 = SKID=1, 1 = SKID=0, 2 = SKID=1 with a 4-bit stall counter.
// Each instance has its own scoreboard queue, fed on its own in_fire.
module tb_pipe_stage_buf;

  typedef logic [83:0] ent_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic [19:0] in_ctrl;
  logic        out_ready;

  logic        rdy      [3];
  logic        o_vld    [3];
  logic [63:0] o_data   [3];
  logic [19:0] o_ctrl   [3];
  logic [1:0]  o_occ    [3];
  logic [15:0] stall16  [2];
  logic [3:0]  stall4;

  ent_t sbq [3][$];
  int   n_checks;
  int   n_errors;

  pipe_stage_buf #(.DATA_W(64), .CTRL_W(20), .SKID(1), .CNT_W(16)) u_dut_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(o_vld[0]), .out_ready(out_ready), .out_data(o_data[0]), .out_ctrl(o_ctrl[0]),
    .occ(o_occ[0]), .stall_cnt(stall16[0])
  );

  pipe_stage_buf #(.DATA_W(64), .CTRL_W(20), .SKID(0), .CNT_W(16)) u_dut_single (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(o_vld[1]), .out_ready(out_ready), .out_data(o_data[1]), .out_ctrl(o_ctrl[1]),
    .occ(o_occ[1]), .stall_cnt(stall16[1])
  );

  pipe_stage_buf #(.DATA_W(64), .CTRL_W(20), .SKID(1), .CNT_W(4)) u_dut_cnt4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(o_vld[2]), .out_ready(out_ready), .out_data(o_data[2]), .out_ctrl(o_ctrl[2]),
    .occ(o_occ[2]), .stall_cnt(stall4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard runs on the falling edge, then time advances to just after
  // the next rising edge where directed checks sample.
  task automatic tick();
    ent_t exp;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (o_vld[d] && out_ready) begin
        n_checks++;
        assert (sbq[d].size() != 0)
        else begin
          n_errors++;
          $error("FAIL sb_underflow dut%0d: observed output %0h with empty queue, required none",
                 d, o_data[d]);
        end
        if (sbq[d].size() != 0) begin
          exp = sbq[d].pop_front();
          chk($sformatf("sb_data dut%0d", d), {o_data[d], o_ctrl[d]}, exp);
        end
      end
      if (!o_vld[d]) chk($sformatf("nop_ctrl dut%0d", d), o_ctrl[d], 0);
      if (flush) sbq[d].delete();
      else if (in_valid && rdy[d]) sbq[d].push_back({in_data, in_ctrl});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s out_valid dut%0d", tag, d), o_vld[d], 0);
      chk($sformatf("%s out_data dut%0d", tag, d), o_data[d], 0);
      chk($sformatf("%s out_ctrl dut%0d", tag, d), o_ctrl[d], 0);
      chk($sformatf("%s occ dut%0d", tag, d), o_occ[d], 0);
      chk($sformatf("%s in_ready dut%0d", tag, d), rdy[d], 1);
    end
    chk({tag, " stall dut0"}, stall16[0], 0);
    chk({tag, " stall dut1"}, stall16[1], 0);
    chk({tag, " stall dut2"}, stall4, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    @(posedge clk);
    #1;
    chk_reset_vals("reset");
    for (int d = 0; d < 3; d++) sbq[d].delete();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [63:0] dat, input logic rd);
    in_valid  = v;
    in_data   = dat;
    in_ctrl   = 20'(dat) ^ 20'h80001;
    out_ready = rd;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    #2;
    do_reset();

    // T1: streaming with no back-pressure, one cycle of latency.
    drive(1'b1, 64'hA, 1'b1);
    tick();
    chk("t1 data A", o_data[0], 64'hA);
    chk("t1 ctrl A", o_ctrl[0], 20'hA ^ 20'h80001);
    drive(1'b1, 64'hB, 1'b1);
    tick();
    chk("t1 data B", o_data[0], 64'hB);
    chk("t1 occ", o_occ[0], 1);
    chk("t1 in_ready", rdy[0], 1);
    drive(1'b1, 64'hC, 1'b1);
    tick();
    chk("t1 data C", o_data[0], 64'hC);
    chk("t1 valid", o_vld[0], 1);
    drive(1'b0, 64'h0, 1'b1);
    tick();
    chk("t1 drained", o_vld[0], 0);

    // T2: back-pressure fills head then skid; third beat is held off.
    drive(1'b1, 64'h1, 1'b0);
    tick();
    drive(1'b1, 64'h2, 1'b0);
    tick();
    drive(1'b1, 64'h3, 1'b0);
    tick();
    chk("t2 occ full", o_occ[0], 2);
    chk("t2 in_ready", rdy[0], 0);
    chk("t2 head", o_data[0], 64'h1);
    chk("t2 single in_ready", rdy[1], 0);
    drive(1'b1, 64'h3, 1'b1);
    tick();
    chk("t2 skid to head", o_data[0], 64'h2);
    chk("t2 occ one", o_occ[0], 1);
    chk("t2 in_ready back", rdy[0], 1);
    tick();
    chk("t2 third", o_data[0], 64'h3);
    drive(1'b0, 64'h0, 1'b1);
    tick();
    tick();
    chk("t2 drained", o_vld[0], 0);

    // T3: flush while full, then flush racing an accept.
    drive(1'b1, 64'h7, 1'b0);
    tick();
    drive(1'b1, 64'h8, 1'b0);
    tick();
    chk("t3 full", o_occ[0], 2);
    flush = 1'b1;
    drive(1'b1, 64'h9, 1'b0);
    tick();
    flush = 1'b0;
    chk("t3 occ", o_occ[0], 0);
    chk("t3 valid", o_vld[0], 0);
    chk("t3 ctrl", o_ctrl[0], 0);
    chk("t3 data", o_data[0], 0);
    chk("t3 in_ready", rdy[0], 1);
    chk("t3 single occ", o_occ[1], 0);
    drive(1'b0, 64'h0, 1'b1);
    tick();
    tick();
    chk("t3 no ghost", o_vld[0], 0);
    drive(1'b1, 64'h20, 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, 64'h21, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, 64'h0, 1'b1);
    chk("t3b occ", o_occ[0], 0);
    chk("t3b valid", o_vld[0], 0);
    tick();
    chk("t3b no ghost", o_vld[0], 0);

    // T4: single-entry stage stalled for five cycles.
    do_reset();
    drive(1'b1, 64'h5, 1'b1);
    tick();
    drive(1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4 in_ready", rdy[1], 0);
      tick();
      chk("t4 data stable", o_data[1], 64'h5);
    end
    chk("t4 stall_cnt", stall16[1], 5);
    out_ready = 1'b1;
    #1;
    chk("t4 comb ready", rdy[1], 1);
    chk("t4 skid ready", rdy[0], 1);
    tick();
    chk("t4 drained", o_vld[1], 0);

    // T5: saturation of a 4-bit counter, then reset in the middle of a stall.
    do_reset();
    drive(1'b1, 64'h55, 1'b1);
    tick();
    drive(1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("t5 sat", stall4, 15);
    chk("t5 wide cnt", stall16[0], 20);
    for (int i = 0; i < 3; i++) tick();
    chk("t5 sat hold", stall4, 15);
    chk("t5 valid before rst", o_vld[2], 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t5 async");
    for (int d = 0; d < 3; d++) sbq[d].delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T6: random traffic with occasional flush on every instance at once.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom(), $urandom()};
      in_ctrl   = 20'($urandom());
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 99) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("t6 drained dut%0d", d), sbq[d].size(), 0);
      chk($sformatf("t6 idle dut%0d", d), o_vld[d], 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
